// File: rtl/pic_pkg.sv
// Shared definitions for the PIC-style program counter slice.
// Default geometry and the PC operation encoding used by control.
package pic_pkg;

    localparam int DEF_PC_WIDTH    = 13;
    localparam int DEF_JUMP_WIDTH  = 11;
    localparam int DEF_STACK_DEPTH = 8;

    typedef enum logic [2:0] {
        PC_HOLD = 3'd0,
        PC_INCR = 3'd1,
        PC_GOTO = 3'd2,
        PC_CALL = 3'd3,
        PC_RET  = 3'd4,
        PC_PCL  = 3'd5
    } pc_op_e;

endpackage

// File: rtl/pc_stack_unit_if.sv
// Control/status bundle between the decoder FSM and the PC unit.
// master = control side, slave = pc_stack_unit.
interface pc_stack_unit_if
    import pic_pkg::*;
#(
    parameter int PC_WIDTH    = DEF_PC_WIDTH,
    parameter int JUMP_WIDTH  = DEF_JUMP_WIDTH,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH
);
    localparam int SP_WIDTH     = $clog2(STACK_DEPTH);
    localparam int PCLATH_WIDTH = PC_WIDTH - 8;

    logic                    pc_incr_en;
    logic                    pc_j_en;
    logic                    call_en;
    logic                    ret_en;
    logic [JUMP_WIDTH-1:0]   pc_j_addr;
    logic                    pclath_wr_en;
    logic [PCLATH_WIDTH-1:0] pclath_in;
    logic                    pcl_wr_en;
    logic [7:0]              pcl_in;
    logic                    flag_clr;
    logic [PC_WIDTH-1:0]     pc_out;
    logic [PCLATH_WIDTH-1:0] pclath_out;
    logic [SP_WIDTH:0]       stack_level;
    logic                    stack_overflow;
    logic                    stack_underflow;

    modport master (
        output pc_incr_en, pc_j_en, call_en, ret_en, pc_j_addr,
        output pclath_wr_en, pclath_in, pcl_wr_en, pcl_in, flag_clr,
        input  pc_out, pclath_out, stack_level,
        input  stack_overflow, stack_underflow
    );

    modport slave (
        input  pc_incr_en, pc_j_en, call_en, ret_en, pc_j_addr,
        input  pclath_wr_en, pclath_in, pcl_wr_en, pcl_in, flag_clr,
        output pc_out, pclath_out, stack_level,
        output stack_overflow, stack_underflow
    );

endinterface

// File: rtl/hw_stack.sv
// Circular return-address stack with saturating level counter.
// Sticky overflow/underflow flags; pop data is mem[sp-1].
module hw_stack
    import pic_pkg::*;
#(
    parameter int WIDTH = DEF_PC_WIDTH,
    parameter int DEPTH = DEF_STACK_DEPTH,
    localparam int SPW  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    input  logic             flag_clr,
    output logic [WIDTH-1:0] pop_data,
    output logic [SPW:0]     level,
    output logic             overflow,
    output logic             underflow
);
    localparam logic [SPW:0] FULL = (SPW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [SPW-1:0]   sp_q, sp_d, sp_m1;
    logic [SPW:0]     lvl_q, lvl_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             set_ovf, set_unf;

    assign sp_m1    = sp_q - SPW'(1);
    assign pop_data = mem_q[sp_m1];

    // Pointer/level update; a flag set wins over a same-cycle clear.
    always_comb begin
        sp_d    = sp_q;
        lvl_d   = lvl_q;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        if (pop) begin
            sp_d = sp_m1;
            if (lvl_q == '0) set_unf = 1'b1;
            else             lvl_d   = lvl_q - 1'b1;
        end else if (push) begin
            sp_d = sp_q + SPW'(1);
            if (lvl_q == FULL) set_ovf = 1'b1;
            else               lvl_d   = lvl_q + 1'b1;
        end
        ovf_d = set_ovf | (ovf_q & ~flag_clr);
        unf_d = set_unf | (unf_q & ~flag_clr);
    end

    // Pointer, level and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q  <= '0;
            lvl_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            lvl_q <= lvl_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Storage is not reset; a full push overwrites the oldest slot.
    always_ff @(posedge clk) begin
        if (!rst && push && !pop) mem_q[sp_q] <= push_data;
    end

    assign level     = lvl_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter and PCLATH with a hardware return stack.
// pc_out addresses program ROM directly.
module pc_stack_unit
    import pic_pkg::*;
#(
    parameter int PC_WIDTH    = DEF_PC_WIDTH,
    parameter int JUMP_WIDTH  = DEF_JUMP_WIDTH,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
    input logic             clk,
    input logic             rst,
    pc_stack_unit_if.slave  bus
);
    localparam int SP_WIDTH     = $clog2(STACK_DEPTH);
    localparam int PCLATH_WIDTH = PC_WIDTH - 8;
    localparam int HI_W         = PC_WIDTH - JUMP_WIDTH;

    pc_op_e                  op;
    logic [PC_WIDTH-1:0]     pc_q, pc_d, pc_plus1, jump_tgt, pop_data;
    logic [PCLATH_WIDTH-1:0] pclath_q, pclath_d;
    logic [SP_WIDTH:0]       level;
    logic                    ovf, unf;

    assign pc_plus1 = pc_q + PC_WIDTH'(1);
    assign jump_tgt = {pclath_q[PCLATH_WIDTH-1 -: HI_W], bus.pc_j_addr};

    // Resolve the single winning PC operation for this cycle.
    always_comb begin
        op = PC_HOLD;
        if (bus.ret_en)         op = PC_RET;
        else if (bus.call_en)   op = PC_CALL;
        else if (bus.pc_j_en)   op = PC_GOTO;
        else if (bus.pcl_wr_en) op = PC_PCL;
        else if (bus.pc_incr_en) op = PC_INCR;
    end

    // Next PC and PCLATH; jumps read the pre-write PCLATH.
    always_comb begin
        pc_d     = pc_q;
        pclath_d = bus.pclath_wr_en ? bus.pclath_in : pclath_q;
        case (op)
            PC_RET:  pc_d = pop_data;
            PC_CALL: pc_d = jump_tgt;
            PC_GOTO: pc_d = jump_tgt;
            PC_PCL:  pc_d = {pclath_q, bus.pcl_in};
            PC_INCR: pc_d = pc_plus1;
            default: pc_d = pc_q;
        endcase
    end

    // PC and PCLATH registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= '0;
            pclath_q <= '0;
        end else begin
            pc_q     <= pc_d;
            pclath_q <= pclath_d;
        end
    end

    hw_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (op == PC_CALL),
        .pop       (op == PC_RET),
        .push_data (pc_plus1),
        .flag_clr  (bus.flag_clr),
        .pop_data  (pop_data),
        .level     (level),
        .overflow  (ovf),
        .underflow (unf)
    );

    assign bus.pc_out          = pc_q;
    assign bus.pclath_out      = pclath_q;
    assign bus.stack_level     = level;
    assign bus.stack_overflow  = ovf;
    assign bus.stack_underflow = unf;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Bench for pc_stack_unit: directed scenarios then random ops,
// all checked against a queue/array reference model.
module tb_pc_stack_unit;

    localparam int PCW  = 13;
    localparam int JW   = 11;
    localparam int D    = 8;
    localparam int PLW  = PCW - 8;
    localparam int HIW  = PCW - JW;
    localparam int MASK = (1 << PCW) - 1;

    logic clk;
    logic rst;

    pc_stack_unit_if bus ();

    pc_stack_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int m_pc, m_pclath, m_sp, m_lvl;
    bit m_ov, m_un;
    int m_mem [D];
    bit m_wr  [D];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic clear_in();
        rst              = 1'b0;
        bus.pc_incr_en   = 1'b0;
        bus.pc_j_en      = 1'b0;
        bus.call_en      = 1'b0;
        bus.ret_en       = 1'b0;
        bus.pc_j_addr    = '0;
        bus.pclath_wr_en = 1'b0;
        bus.pclath_in    = '0;
        bus.pcl_wr_en    = 1'b0;
        bus.pcl_in       = '0;
        bus.flag_clr     = 1'b0;
    endtask

    // Apply the current inputs for one clock, advance the model,
    // compare every output, then drop all inputs.
    task automatic tick();
        int npc, ncl, pcp1, jt, idx;
        bit sov, sun;
        npc  = m_pc;
        ncl  = bus.pclath_wr_en ? int'(bus.pclath_in) : m_pclath;
        pcp1 = (m_pc + 1) & MASK;
        jt   = ((m_pclath >> (PLW - HIW)) << JW) | int'(bus.pc_j_addr);
        sov  = 0;
        sun  = 0;
        if (rst) begin
            m_pc = 0; m_pclath = 0; m_sp = 0; m_lvl = 0;
            m_ov = 0; m_un = 0;
        end else begin
            if (bus.ret_en) begin
                idx  = (m_sp + D - 1) % D;
                npc  = m_mem[idx];
                m_sp = idx;
                if (m_lvl == 0) sun = 1;
                else            m_lvl--;
            end else if (bus.call_en) begin
                m_mem[m_sp] = pcp1;
                m_wr[m_sp]  = 1;
                m_sp = (m_sp + 1) % D;
                if (m_lvl == D) sov = 1;
                else            m_lvl++;
                npc = jt;
            end else if (bus.pc_j_en) begin
                npc = jt;
            end else if (bus.pcl_wr_en) begin
                npc = (m_pclath << 8) | int'(bus.pcl_in);
            end else if (bus.pc_incr_en) begin
                npc = pcp1;
            end
            m_ov = sov | (m_ov & ~bus.flag_clr);
            m_un = sun | (m_un & ~bus.flag_clr);
            m_pc = npc;
            m_pclath = ncl;
        end
        @(posedge clk);
        #1;
        chk("pc_out", 32'(bus.pc_out), 32'(m_pc));
        chk("pclath_out", 32'(bus.pclath_out), 32'(m_pclath));
        chk("stack_level", 32'(bus.stack_level), 32'(m_lvl));
        chk("overflow", 32'(bus.stack_overflow), 32'(m_ov));
        chk("underflow", 32'(bus.stack_underflow), 32'(m_un));
        clear_in();
    endtask

    task automatic op_incr();
        bus.pc_incr_en = 1'b1; tick();
    endtask

    task automatic op_pclath(input int v);
        bus.pclath_wr_en = 1'b1; bus.pclath_in = PLW'(v); tick();
    endtask

    task automatic op_pcl(input int v);
        bus.pcl_wr_en = 1'b1; bus.pcl_in = 8'(v); tick();
    endtask

    task automatic op_goto(input int a);
        bus.pc_j_en = 1'b1; bus.pc_j_addr = JW'(a); tick();
    endtask

    task automatic op_call(input int a);
        bus.call_en = 1'b1; bus.pc_j_addr = JW'(a); tick();
    endtask

    task automatic op_ret();
        bus.ret_en = 1'b1; tick();
    endtask

    initial begin
        clk = 1'b0;
        m_pc = 0; m_pclath = 0; m_sp = 0; m_lvl = 0;
        m_ov = 0; m_un = 0;
        for (int i = 0; i < D; i++) begin
            m_mem[i] = 0;
            m_wr[i]  = 0;
        end
        clear_in();

        rst = 1'b1; tick();
        chk("rst_pc", 32'(bus.pc_out), 32'h0);
        chk("rst_lvl", 32'(bus.stack_level), 32'h0);
        repeat (3) op_incr();
        chk("incr3", 32'(bus.pc_out), 32'h3);

        op_pclath('h1F);
        op_pcl('hFF);
        chk("pc_max", 32'(bus.pc_out), 32'h1FFF);
        op_incr();
        chk("pc_wrap", 32'(bus.pc_out), 32'h0);

        op_pclath('h18);
        op_goto('h123);
        chk("goto", 32'(bus.pc_out), 32'h1923);
        op_pcl('h45);
        chk("pcl", 32'(bus.pc_out), 32'h1845);

        op_pclath(0);
        op_pcl('h10);
        op_call('h200);
        op_call('h300);
        chk("nest_lvl", 32'(bus.stack_level), 32'h2);
        op_ret();
        chk("ret1", 32'(bus.pc_out), 32'h201);
        op_ret();
        chk("ret2", 32'(bus.pc_out), 32'h11);
        chk("nest_lvl0", 32'(bus.stack_level), 32'h0);

        for (int k = 0; k < 9; k++) op_call('h100 + 'h10 * k);
        chk("ovf_flag", 32'(bus.stack_overflow), 32'h1);
        chk("ovf_lvl", 32'(bus.stack_level), 32'h8);
        repeat (8) op_ret();
        chk("lifo_last", 32'(bus.pc_out), 32'h101);
        chk("no_unf", 32'(bus.stack_underflow), 32'h0);
        op_ret();
        chk("unf_flag", 32'(bus.stack_underflow), 32'h1);
        chk("unf_pc", 32'(bus.pc_out), 32'h171);

        bus.flag_clr = 1'b1; tick();
        chk("clr_ovf", 32'(bus.stack_overflow), 32'h0);
        op_call('h40);
        bus.call_en = 1'b1; bus.ret_en = 1'b1;
        bus.pc_j_addr = JW'('h7FF); tick();
        chk("callret_pc", 32'(bus.pc_out), 32'h172);
        chk("callret_lvl", 32'(bus.stack_level), 32'h0);

        op_pclath('h10);
        bus.pclath_wr_en = 1'b1; bus.pclath_in = PLW'('h08);
        bus.pc_j_en = 1'b1; bus.pc_j_addr = JW'('h005); tick();
        chk("old_pclath", 32'(bus.pc_out), 32'h1005);
        chk("new_pclath", 32'(bus.pclath_out), 32'h08);

        repeat (3) op_call('h20);
        rst = 1'b1; bus.call_en = 1'b1; bus.pc_j_addr = JW'('h55);
        tick();
        chk("rstmid_pc", 32'(bus.pc_out), 32'h0);
        chk("rstmid_lvl", 32'(bus.stack_level), 32'h0);

        for (int k = 0; k < 8; k++) op_call('h30 + k);
        bus.flag_clr = 1'b1; bus.call_en = 1'b1;
        bus.pc_j_addr = JW'('h60); tick();
        chk("clr_vs_set", 32'(bus.stack_overflow), 32'h1);

        for (int n = 0; n < 600; n++) begin
            rst              = ($urandom_range(0, 59) == 0);
            bus.pc_incr_en   = $urandom_range(0, 1) == 1;
            bus.pc_j_en      = ($urandom_range(0, 5) == 0);
            bus.call_en      = ($urandom_range(0, 3) == 0);
            bus.pcl_wr_en    = ($urandom_range(0, 7) == 0);
            bus.pclath_wr_en = ($urandom_range(0, 5) == 0);
            bus.flag_clr     = ($urandom_range(0, 9) == 0);
            bus.pc_j_addr    = JW'($urandom);
            bus.pclath_in    = PLW'($urandom);
            bus.pcl_in       = 8'($urandom);
            bus.ret_en       = ($urandom_range(0, 3) == 0) &&
                               (m_lvl > 0 || m_wr[(m_sp + D - 1) % D]);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
Parametrised successor to the PIC16F program counter. Holds PC and PCLATH. Adds a hardware return-address stack for CALL/RETURN/RETLW/RETFIE, with sticky overflow/underflow flags and a stack-level output. Sits between the instruction decoder/control FSM and program memory addressing. pc_out drives the program ROM address.

Parameters:
PC_WIDTH, 13, program counter width in bits.
JUMP_WIDTH, 11, literal jump address width for GOTO/CALL; must be less than PC_WIDTH.
STACK_DEPTH, 8, return-stack entries; power of two, at least 2.
SP_WIDTH, $clog2(STACK_DEPTH), stack pointer width (derived; do not override).
PCLATH_WIDTH, PC_WIDTH-8, PCLATH register width (derived).

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
pc_incr_en  in  1  pc <= pc + 1
pc_j_en  in  1  GOTO: pc <= {pclath[top PC_WIDTH-JUMP_WIDTH bits], pc_j_addr}
call_en  in  1  CALL: push pc+1, then jump as for pc_j_en
ret_en  in  1  RETURN/RETLW/RETFIE: pop top of stack into pc
pc_j_addr  in  JUMP_WIDTH  literal jump target
pclath_wr_en  in  1  write PCLATH
pclath_in  in  PCLATH_WIDTH  PCLATH write data
pcl_wr_en  in  1  PCL write: pc <= {pclath, pcl_in}
pcl_in  in  8  PCL write data
flag_clr  in  1  clear sticky stack_overflow and stack_underflow
pc_out  out  PC_WIDTH  current PC
pclath_out  out  PCLATH_WIDTH  current PCLATH register (not pc upper bits)
stack_level  out  SP_WIDTH+1  valid entries, 0..STACK_DEPTH
stack_overflow  out  1  sticky; a push occurred while full
stack_underflow  out  1  sticky; a pop occurred while empty

Behaviour:
- Reset: pc=0, pclath=0, sp=0, stack_level=0, both flags 0. Stack RAM contents need not be cleared. Reset mid-operation overrides every other input in that cycle.
- All outputs are registered. Effects are visible the cycle after the enable is sampled. No handshakes; enables are single-cycle pulses from control.
- PC update priority per cycle, highest first: ret_en > call_en > pc_j_en > pcl_wr_en > pc_incr_en. Only the highest-priority active operation updates pc.
- ret_en with call_en in the same cycle: the pop happens and the call is ignored entirely (no push, no jump). A control bug is the only cause; no flag.
- pclath_wr_en is independent of the PC operations. It updates pclath in the same edge as any PC operation. Any PC operation that reads pclath in that same cycle uses the old pclath value.
- Arithmetic: pc+1 is modulo 2^PC_WIDTH (0x1FFF+1 = 0x0000). The pushed value is pc+1, with the same wrap.
- Stack is circular with write pointer sp (SP_WIDTH bits, wraps modulo STACK_DEPTH).
- Push: mem[sp] <= pc+1 and sp <= sp+1. stack_level increments, saturating at STACK_DEPTH. Push when stack_level==STACK_DEPTH overwrites the oldest entry and sets stack_overflow.
- Pop: sp <= sp-1 and pc <= mem[sp-1]. stack_level decrements, saturating at 0. Pop when stack_level==0 still wraps sp, loads whatever mem[sp-1] holds, and sets stack_underflow.
- Flags are sticky until rst or flag_clr. A set condition coincident with flag_clr leaves the flag set.
- The jump high bits are pclath[PCLATH_WIDTH-1 -: PC_WIDTH-JUMP_WIDTH]. The PCL write uses the full pclath.

Decomposition:
- Shared package pic_pkg: PC_WIDTH, JUMP_WIDTH, STACK_DEPTH defaults, and the pc_op_e enum (PC_HOLD, PC_INCR, PC_GOTO, PC_CALL, PC_RET, PC_PCL). Control uses pc_op_e when it encodes the enables.
- One sub-module: hw_stack. It holds the circular return-address stack, pointer, level counter and flags, with a push/pop/data interface.
- pc_stack_unit owns the pc and pclath registers and the priority mux.

Test Plan:
- Reset/increment: rst 1 cycle, then 3 cycles of pc_incr_en -> pc_out=3, pclath_out=0, stack_level=0, flags 0. Set pc to 0x1FFF via a PCL write with pclath=0x1F, pcl_in=0xFF; then incr -> pc_out=0x0000.
- GOTO/PCL with PCLATH: pclath_in=0x18 written; then pc_j_en with pc_j_addr=0x123 -> pc_out=0x1923. pcl_wr_en with pcl_in=0x45 -> pc_out=0x1845.
- Call/return nesting: at pc=0x0010 call to 0x200; at pc=0x0200 call to 0x300 -> stack_level=2. ret -> pc=0x0201; ret -> pc=0x0011; stack_level=0, no flags.
- Overflow wrap: 9 calls from distinct PCs -> stack_overflow=1, stack_level=8. 8 rets return the last 8 return addresses in LIFO order; a 9th ret sets stack_underflow=1.
- Simultaneous events: call_en+ret_en -> pop only, no push. pclath_wr_en (0x08) concurrent with pc_j_en (pc_j_addr=0x005), old pclath=0x10 -> pc=0x1005, then pclath_out=0x08.
- Reset mid-stack: 3 pushes, then rst asserted together with call_en -> pc=0, stack_level=0, flags 0. flag_clr coincident with a new overflow -> flag stays 1.
